mem_arbiter: RTL

- Shares the single RAM port among the instruction and data caches of CPUS cores.
- Sits between the per-core icache/dcache bus signals and the RAM model.
- Grants one requester at a time: data before instruction; round-robin across cores within each class.
- Holds each grant until the RAM reports ACCESS, the requester withdraws, or the RAM reports ERROR.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/rr_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: RAM handshake, arbiter FSM state and grant record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic {IDLE, SERVE} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;

  // Wide enough for the largest supported core count (2); CPUS = 1 simply keeps it at 0.
  localparam int unsigned CORE_W = 1;
  typedef logic [CORE_W-1:0] core_t;

  typedef struct packed {
    arb_src_t src;
    core_t    core;
  } grant_t;

  function automatic core_t rr_next(input core_t c, input int unsigned n);
    return (n > 1) ? core_t'((32'(c) + 32'd1) % n) : '0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr_i, returned one-hot.
module rr_pick
  import cpu_types_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req_i,
  input  core_t        ptr_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  // Core c sits at offset i from the pointer when ptr == (c - i) mod N; all indices stay constant.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (!valid_o && req_i[c] && (32'(ptr_i) == (c + N - i) % N)) begin
          gnt_o[c] = 1'b1;
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates per-core icache/dcache requests onto the single RAM port.
// Optional performance counters (grant_cnt/stall_cnt) under MEM_ARBITER_PERF_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  output logic [CPUS-1:0]      iwait,
  output word_t [CPUS-1:0]     iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
`ifdef MEM_ARBITER_PERF_EN
  ,
  output word_t [CPUS*2-1:0]   grant_cnt,
  output word_t                stall_cnt
`endif
);

  arb_state_t      state_q, state_d;
  grant_t          grant_q, grant_d;
  core_t           irr_q, irr_d, drr_q, drr_d;
  logic [CPUS-1:0] dreq;
  logic [CPUS-1:0] i_gnt, d_gnt;
  logic            i_vld, d_vld;
  core_t           i_idx, d_idx;
  logic            live, done;

  assign dreq  = dREN | dWEN;
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  rr_pick #(.N(CPUS)) u_ipick (.req_i(iREN), .ptr_i(irr_q), .gnt_o(i_gnt), .valid_o(i_vld));
  rr_pick #(.N(CPUS)) u_dpick (.req_i(dreq), .ptr_i(drr_q), .gnt_o(d_gnt), .valid_o(d_vld));

  always_comb begin
    i_idx = '0;
    d_idx = '0;
    for (int unsigned c = 0; c < CPUS; c++) begin
      if (i_gnt[c]) i_idx = core_t'(c);
      if (d_gnt[c]) d_idx = core_t'(c);
    end
  end

  // RAM side follows the granted source live; a withdrawn request blanks the bus at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    live     = 1'b0;
    done     = 1'b0;
    if (state_q == SERVE) begin
      if (grant_q.src == SRC_D) begin
        live = dREN[grant_q.core] | dWEN[grant_q.core];
        if (live) begin
          ramWEN   = dWEN[grant_q.core];
          ramREN   = dREN[grant_q.core] & ~dWEN[grant_q.core];
          ramaddr  = daddr[grant_q.core];
          ramstore = dstore[grant_q.core];
        end
      end else begin
        live = iREN[grant_q.core];
        if (live) begin
          ramREN  = 1'b1;
          ramaddr = iaddr[grant_q.core];
        end
      end
      done = live && (ramstate == ACCESS);
      if (done) begin
        if (grant_q.src == SRC_D) dwait[grant_q.core] = 1'b0;
        else                      iwait[grant_q.core] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    irr_d   = irr_q;
    drr_d   = drr_q;
    if (state_q == IDLE) begin
      if (d_vld) begin
        grant_d = '{src: SRC_D, core: d_idx};
        state_d = SERVE;
      end else if (i_vld) begin
        grant_d = '{src: SRC_I, core: i_idx};
        state_d = SERVE;
      end
    end else begin
      if (!live || done || ramstate == ERROR) state_d = IDLE;
      if (done) begin
        if (grant_q.src == SRC_D) drr_d = rr_next(grant_q.core, CPUS);
        else                      irr_d = rr_next(grant_q.core, CPUS);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '{src: SRC_I, core: '0};
      irr_q   <= '0;
      drr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      irr_q   <= irr_d;
      drr_q   <= drr_d;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  logic              stall;
  logic [CORE_W:0]   gidx;

  assign stall = (|(iREN & iwait)) | (|(dreq & dwait));
  assign gidx  = {grant_q.core, grant_q.src == SRC_D};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (done && grant_cnt[gidx] != '1) grant_cnt[gidx] <= grant_cnt[gidx] + 32'd1;
      if (stall && stall_cnt != '1)      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
